// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - dual-issue instruction fetch queue (circular buffer, pair in / pair out)
//
// Purpose:
//   Buffers fetched instruction pairs between the fetch and steering stages.
//   Accepts one full pair per cycle and presents the two oldest entries.
//   Optional build macro: FETCH_QUEUE_BYPASS_EN (empty-queue combinational bypass).
//
// Ports:
//   clk              in   rising-edge clock
//   reset            in   synchronous active-high reset
//   in_valid         in   incoming fetch pair is valid
//   in_instruction0  in   older incoming instruction
//   in_instruction1  in   younger incoming instruction
//   in_ready         out  queue has room for a full pair (registered count only)
//   flush            in   discard everything queued, including this cycle's input
//   stall            in   hold the presented pair, no consumption
//   instruction0_out out  head entry (or NOP)
//   instruction1_out out  head+1 entry (or NOP)
//   out_valid        out  at least one real instruction is presented
//   count            out  number of stored instructions

`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef NOP_INSTRUCTION
`define NOP_INSTRUCTION 32'h0000_0013
`endif

module fetch_queue #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [`INST_WIDTH-1:0]   in_instruction0,
  input  logic [`INST_WIDTH-1:0]   in_instruction1,
  output logic                     in_ready,
  input  logic                     flush,
  input  logic                     stall,
  output logic [`INST_WIDTH-1:0]   instruction0_out,
  output logic [`INST_WIDTH-1:0]   instruction1_out,
  output logic                     out_valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [`INST_WIDTH-1:0] NOP = `NOP_INSTRUCTION;

  logic [`INST_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [CW-1:0]          pop_n;
  logic                   push_en;
  logic                   pop_en;
  logic                   bypass_active;

  // Ready looks only at the registered count so it never forms a
  // combinational path back from the steering stage's stall.
  assign in_ready = (count_q <= CW'(DEPTH - 2));
  assign count    = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass_active = (count_q == '0) && in_valid && !flush;
`else
  assign bypass_active = 1'b0;
`endif

  always_comb begin
    instruction0_out = NOP;
    instruction1_out = NOP;
    out_valid        = 1'b0;
    if (count_q >= CW'(2)) begin
      instruction0_out = mem_q[rd_ptr_q];
      instruction1_out = mem_q[rd_ptr_q + PW'(1)];
      out_valid        = 1'b1;
    end else if (count_q == CW'(1)) begin
      instruction0_out = mem_q[rd_ptr_q];
      out_valid        = 1'b1;
    end else if (bypass_active) begin
      instruction0_out = in_instruction0;
      instruction1_out = in_instruction1;
      out_valid        = 1'b1;
    end
  end

  always_comb begin
    // A bypassed pair that is consumed this cycle never enters storage;
    // a stalled bypass pair is written so it is re-presented from the queue.
    push_en = in_valid && in_ready && !flush && !(bypass_active && !stall);
    // Queue-side pop only; a bypassed pair is consumed without touching rd_ptr.
    pop_en  = out_valid && !stall && !flush && !bypass_active;
    pop_n   = '0;
    if (pop_en) begin
      pop_n = (count_q >= CW'(2)) ? CW'(2) : CW'(1);
    end
    count_d  = count_q + (push_en ? CW'(2) : CW'(0)) - pop_n;
    wr_ptr_d = push_en ? wr_ptr_q + PW'(2) : wr_ptr_q;
    rd_ptr_d = rd_ptr_q + PW'(pop_n);
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage carries no reset; stale contents are never presented
  // because the outputs are qualified by count.
  always_ff @(posedge clk) begin
    if (push_en && !reset) begin
      mem_q[wr_ptr_q]          <= in_instruction0;
      mem_q[wr_ptr_q + PW'(1)] <= in_instruction1;
    end
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have one parameter: DEPTH, default 8, the queue capacity in instructions (power of two, at least 4).
REQ-002 The block SHALL use the global INST_WIDTH and NOP_INSTRUCTION definitions for instruction width and fill value.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  the fetch pair on in_instruction0/1 is valid this cycle.
REQ-007 in_instruction0  input  INST_WIDTH  older fetched instruction.
REQ-008 in_instruction1  input  INST_WIDTH  younger fetched instruction.
REQ-009 in_ready  output  1  queue can accept one full pair this cycle.
REQ-010 flush  input  1  discards all queued instructions (branch redirect).
REQ-011 stall  input  1  from the steering stage: the presented pair is held and is not consumed.
REQ-012 instruction0_out  output  INST_WIDTH  oldest queued instruction (head).
REQ-013 instruction1_out  output  INST_WIDTH  second-oldest queued instruction (head+1).
REQ-014 out_valid  output  1  at least one real instruction is presented.
REQ-015 count  output  clog2(DEPTH)+1  number of stored instructions.

Function
REQ-016 The block SHALL be a circular buffer of DEPTH entries with read and write pointers that wrap modulo DEPTH.
REQ-017 in_ready SHALL be 1 exactly when the registered count is at most DEPTH-2; it SHALL NOT depend on a same-cycle pop.
REQ-018 A push SHALL occur when in_valid, in_ready and not flush are all true; it writes in_instruction0 then in_instruction1 to consecutive entries and advances the write pointer by 2.
REQ-019 When count is 2 or more, the outputs SHALL be head -> instruction0_out and head+1 -> instruction1_out, with out_valid=1.
REQ-020 When count is 1, the outputs SHALL be head -> instruction0_out and NOP_INSTRUCTION -> instruction1_out, with out_valid=1.
REQ-021 When count is 0, both outputs SHALL be NOP_INSTRUCTION and out_valid SHALL be 0 (subject to REQ-030).
REQ-022 A pop SHALL occur when out_valid=1, stall=0 and flush=0; it removes min(count,2) entries and advances the read pointer by the same amount.
REQ-023 When stall=1, the pair SHALL be held: there is no pop, and the identical pair is presented next cycle unless a flush occurs.
REQ-024 A simultaneous push and pop SHALL give count_next = count + 2 - popped.
REQ-025 Count SHALL never exceed DEPTH and never underflow; a push while in_ready=0 SHALL be ignored.
REQ-026 Flush SHALL take priority over push and pop: in the next cycle count=0, both pointers=0, and the same-cycle in_valid is discarded.

Reset
REQ-027 While reset is asserted at a clock edge, the block SHALL set count=0 and both pointers=0; it SHALL then drive out_valid=0, both outputs=NOP_INSTRUCTION and in_ready=1.
REQ-028 Reset SHALL take priority over flush, push and pop, and SHALL behave identically when asserted mid-stall or while the queue is full.
REQ-029 Stored entry contents SHALL NOT require reset.

Configuration
REQ-030 With FETCH_QUEUE_BYPASS_EN defined, when count=0, in_valid=1 and flush=0, the block SHALL present in_instruction0/1 combinationally with out_valid=1.
- With stall=0, the pair SHALL be consumed and not written.
- With stall=1, the pair SHALL be written, so it is re-presented from the queue next cycle.
REQ-031 Without FETCH_QUEUE_BYPASS_EN, a pushed instruction SHALL first appear on the outputs exactly one cycle after the push.

Verification
REQ-032 After reset, push pair A,B -> next cycle out A,B, out_valid=1, count=2; with stall=0 -> following cycle count=0, out_valid=0, outputs NOP.
REQ-033 Queue holds A,B,C; stall=1 for one cycle, then stall=0 -> A,B presented for two cycles, then C with NOP in slot 1, count=1.
REQ-034 With DEPTH=8, push 4 pairs with stall=1 -> count=8, in_ready=0; a fifth pair is ignored; one pop -> count=6, in_ready=1; pointer wrap continues in order without loss.
REQ-035 count=6 with push, flush and stall=0 in the same cycle -> next cycle count=0, out_valid=0, the pushed pair is absent.
REQ-036 Bypass check, empty queue with in_valid pair X,Y and stall=0: with FETCH_QUEUE_BYPASS_EN, X,Y appear the same cycle and count stays 0; without it, X,Y appear next cycle and count=2.
